// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
//
// Purpose:
//   Parametrised synchronous up/down counter with a programmable modulus,
//   an enable-gated prescaler, direction select, clamped parallel load, a
//   combinational terminal-count flag and a registered wrap pulse. The wrap
//   pulse of one instance is meant to drive the enable of the next one, which
//   lets several instances be chained into multi-digit counters.
//
// Parameters:
//   WIDTH     counter width in bits (qout bit 0 = LSB)
//   MODULUS   count range 0..MODULUS-1, legal 2..2**WIDTH
//   PRESCALE  enabled cycles per count step, legal >= 1
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-high reset
//   en        in   1      count enable; advances the prescaler when high
//   dir       in   1      1 = count up, 0 = count down
//   load      in   1      synchronous parallel load, highest priority
//   load_val  in   WIDTH  value to load; clamped to MODULUS-1
//   qout      out  WIDTH  registered count value
//   tc        out  1      terminal count: top when counting up, 0 when down
//   wrap      out  1      one-cycle pulse in the cycle after qout wrapped
//
// Configuration:
//   UDCNT_SATURATE_EN  when defined, the counter holds at the end of its range
//                      instead of wrapping, and wrap is never asserted.
// -----------------------------------------------------------------------------
module param_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] qout,
  output logic             tc,
  output logic             wrap
);

  // A 1-cycle prescaler still gets a 1-bit register that simply stays at 0.
  localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] TOP      = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre;
  logic [PW-1:0]    pre_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             step;
  logic             q_oor;     // qout outside 0..MODULUS-1
  logic             load_oor;  // load_val outside 0..MODULUS-1

  // With a full binary modulus every code is in range, so the range checks
  // are only built when there are unused codes above TOP.
  generate
    if (MODULUS < (2 ** WIDTH)) begin : g_range_chk
      assign q_oor    = (qout > TOP);
      assign load_oor = (load_val > TOP);
    end else begin : g_no_range_chk
      assign q_oor    = 1'b0;
      assign load_oor = 1'b0;
    end
  endgenerate

  assign step = en & (pre == PRE_LAST);

  // Terminal count tracks the live direction, so it is valid even in reset.
  assign tc = dir ? (qout == TOP) : (qout == '0);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    pre_nxt  = pre;
    q_nxt    = qout;
    wrap_nxt = 1'b0;

    if (load) begin
      // Load discards any coincident step and restarts the prescaler.
      q_nxt   = load_oor ? TOP : load_val;
      pre_nxt = '0;
    end else if (en) begin
      pre_nxt = step ? '0 : pre + PW'(1);
      if (step) begin
        if (q_oor) begin
          // Recovery from an illegal value: restart silently at 0.
          q_nxt = '0;
        end else if (dir) begin
          if (qout == TOP) begin
`ifdef UDCNT_SATURATE_EN
            q_nxt = qout;
`else
            q_nxt    = '0;
            wrap_nxt = 1'b1;
`endif
          end else begin
            q_nxt = qout + WIDTH'(1);
          end
        end else begin
          if (qout == '0) begin
`ifdef UDCNT_SATURATE_EN
            q_nxt = qout;
`else
            q_nxt    = TOP;
            wrap_nxt = 1'b1;
`endif
          end else begin
            q_nxt = qout - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (reset) begin
      qout <= '0;
      pre  <= '0;
      wrap <= 1'b0;
    end else begin
      qout <= q_nxt;
      pre  <= pre_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule
